// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states,
// instruction opcode/funct values and the ALU operation codes used by the ALU mux.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EX_R    = 4'd2,
    S_WB_R    = 4'd3,
    S_EX_ADDR = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_WB_LW   = 4'd7,
    S_WB_I    = 4'd8,
    S_EX_BEQ  = 4'd9,
    S_EX_J    = 4'd10
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_operation;
    logic       illegal;
  } ctrl_t;

  // Quiescent control word: nothing enabled, ALU left on ADD.
  localparam ctrl_t CTRL_IDLE = '{
    pc_write: 1'b0, iord: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
    ir_write: 1'b0, reg_dst: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b0,
    alu_src_a: 2'b00, alu_src_b: 2'b00, pc_source: 2'b00,
    alu_operation: ALU_ADD, illegal: 1'b0
  };

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: IR fields and flags in, enables and selects out.
interface multi_cycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic [2:0] alu_operation;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, pc_source, alu_operation, illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, pc_source, alu_operation, illegal, state
  );
endinterface

// File: rtl/alu_op_decode.sv
// R-type funct decoder: ALU operation, legality and the srl flag (shamt on ALU A).
module alu_op_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_operation_o,
  output logic       legal_o,
  output logic       is_srl_o
);

  always_comb begin
    alu_operation_o = ALU_ADD;
    legal_o         = 1'b1;
    is_srl_o        = 1'b0;
    case (funct_i)
      FN_ADD: alu_operation_o = ALU_ADD;
      FN_SUB: alu_operation_o = ALU_SUB;
      FN_AND: alu_operation_o = ALU_AND;
      FN_OR:  alu_operation_o = ALU_OR;
      FN_XOR: alu_operation_o = ALU_XOR;
      FN_NOR: alu_operation_o = ALU_NOR;
      FN_SLT: alu_operation_o = ALU_SLT;
      FN_SRL: begin
        alu_operation_o = ALU_SRL;
        is_srl_o        = 1'b1;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Moore control FSM for the multi-cycle MIPS datapath; IF and MEM states stretch
// on mem_ready, all outputs are decoded from the state register.
module multi_cycle_ctrl
  import ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  multi_cycle_ctrl_if.master   bus
);

  state_e     state_q, state_d;
  ctrl_t      ctrl;
  logic [2:0] fn_alu_op;
  logic       fn_legal;
  logic       fn_is_srl;
  logic       instr_ok;

  alu_op_decode u_alu_op_decode (
    .funct_i         (bus.funct),
    .alu_operation_o (fn_alu_op),
    .legal_o         (fn_legal),
    .is_srl_o        (fn_is_srl)
  );

  always_comb begin
    instr_ok = 1'b0;
    case (bus.opcode)
      OP_RTYPE:                            instr_ok = fn_legal;
      OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J: instr_ok = 1'b1;
      default:                             instr_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:      if (bus.mem_ready) state_d = S_ID;
      S_ID: begin
        if (!instr_ok)                                 state_d = S_IF;
        else if (bus.opcode == OP_RTYPE)               state_d = S_EX_R;
        else if (bus.opcode == OP_BEQ)                 state_d = S_EX_BEQ;
        else if (bus.opcode == OP_J)                   state_d = S_EX_J;
        else                                           state_d = S_EX_ADDR;
      end
      S_EX_R:    state_d = S_WB_R;
      S_EX_ADDR: begin
        if (bus.opcode == OP_LW)      state_d = S_MEM_RD;
        else if (bus.opcode == OP_SW) state_d = S_MEM_WR;
        else                          state_d = S_WB_I;
      end
      S_MEM_RD:  if (bus.mem_ready) state_d = S_WB_LW;
      S_MEM_WR:  if (bus.mem_ready) state_d = S_IF;
      default:   state_d = S_IF;
    endcase
  end

  // Outputs are forced quiescent while rst_n is low, since IF would otherwise strobe mem_read.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (rst_n) begin
      case (state_q)
        S_IF: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = 2'b01;
          ctrl.ir_write  = bus.mem_ready;
          ctrl.pc_write  = bus.mem_ready;
        end
        S_ID: begin
          ctrl.alu_src_b = 2'b11;
          ctrl.illegal   = !instr_ok;
        end
        S_EX_R: begin
          ctrl.alu_src_a     = fn_is_srl ? 2'b10 : 2'b01;
          ctrl.alu_operation = fn_alu_op;
        end
        S_WB_R: begin
          ctrl.reg_dst   = 1'b1;
          ctrl.reg_write = 1'b1;
        end
        S_EX_ADDR: begin
          ctrl.alu_src_a = 2'b01;
          ctrl.alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          ctrl.iord     = 1'b1;
          ctrl.mem_read = 1'b1;
        end
        S_MEM_WR: begin
          ctrl.iord      = 1'b1;
          ctrl.mem_write = 1'b1;
        end
        S_WB_LW: begin
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
        end
        S_WB_I:  ctrl.reg_write = 1'b1;
        S_EX_BEQ: begin
          ctrl.alu_src_a     = 2'b01;
          ctrl.alu_operation = ALU_SUB;
          ctrl.pc_source     = 2'b01;
          ctrl.pc_write      = bus.zero;
        end
        S_EX_J: begin
          ctrl.pc_source = 2'b10;
          ctrl.pc_write  = 1'b1;
        end
        default: ctrl = CTRL_IDLE;
      endcase
    end
  end

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.iord          = ctrl.iord;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.alu_operation = ctrl.alu_operation;
  assign bus.illegal       = ctrl.illegal;
  assign bus.state         = state_q;

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Moore-style control FSM for the multi-cycle MIPS datapath, sitting directly upstream of the ALU. It decodes the instruction register into a state sequence (IF, ID, EX, MEM, WB) and drives every datapath enable and mux select, including the 3-bit ALU operation code. A ready/wait handshake with instruction/data memory stretches the IF and MEM states.

## Interface
- No parameters.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag, combinational from the current-cycle ALU result.
- `mem_ready`  in  1  memory completes the access this cycle.
- `pc_write`  out  1  PC load enable, already combined with branch condition.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `ir_write`  out  1  IR load enable.
- `reg_dst`  out  1  register write address: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  register write data: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  2  ALU A select: 00 = PC, 01 = reg A, 10 = zero-extended shamt.
- `alu_src_b`  out  2  ALU B select: 00 = reg B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `pc_source`  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_operation`  out  3  000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SRL (B>>A), 110 SUB, 111 SLT.
- `illegal`  out  1  one-cycle pulse on an undecodable instruction.
- `state`  out  4  current state, for debug.

## Operation
- Supported instructions:
  - R-type (op 000000): add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111, slt 101010, srl 000010.
  - lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- Default output values: all enables 0, all selects 0, `alu_operation` = 010. Each state overrides only what is listed below.
- IF: `mem_read`=1, `iord`=0, `alu_src_a`=00, `alu_src_b`=01, ADD, `pc_source`=00.
  - If `mem_ready`=1: `ir_write`=1 and `pc_write`=1, go to ID. Otherwise stay in IF.
- ID: `alu_src_a`=00, `alu_src_b`=11, ADD (branch target into ALUOut). Next state:
  - R with legal funct → EX_R.
  - lw/sw/addi → EX_ADDR.
  - beq → EX_BEQ.
  - j → EX_J.
  - anything else: `illegal`=1, go to IF.
- EX_R: `alu_src_b`=00; `alu_src_a`=10 for srl, else 01; `alu_operation` from funct. Go to WB_R.
- WB_R: `reg_dst`=1, `mem_to_reg`=0, `reg_write`=1. Go to IF.
- EX_ADDR: `alu_src_a`=01, `alu_src_b`=10, ADD. Go to MEM_RD (lw), MEM_WR (sw) or WB_I (addi).
- MEM_RD: `iord`=1, `mem_read`=1. Wait for `mem_ready`, then go to WB_LW.
- MEM_WR: `iord`=1, `mem_write`=1. Wait for `mem_ready`, then go to IF.
- WB_LW: `reg_dst`=0, `mem_to_reg`=1, `reg_write`=1. Go to IF.
- WB_I: `reg_dst`=0, `mem_to_reg`=0, `reg_write`=1. Go to IF.
- EX_BEQ: `alu_src_a`=01, `alu_src_b`=00, SUB, `pc_source`=01, `pc_write`=`zero`. Go to IF.
- EX_J: `pc_source`=10, `pc_write`=1. Go to IF.
- `opcode`/`funct` are sampled from the IR, which is stable from ID onward.

## Timing
- Outputs are combinational from the state register plus `zero`/`mem_ready`, with no added latency.
- With `mem_ready` tied high, cycles per instruction:
  - R-type and addi: 4.
  - lw: 5.
  - sw: 4.
  - beq and j: 3.
  - illegal: 2.
- Every cycle with `mem_ready`=0 in IF, MEM_RD or MEM_WR adds one cycle. Strobes stay asserted and addresses stay stable throughout the wait.
- Reset: `rst_n` low immediately forces state = IF (`state` = 0) and drives all enables (`pc_write`, `ir_write`, `reg_write`, `mem_read`, `mem_write`, `illegal`) to 0; selects 0; `alu_operation` = 010.
  - Reset asserted mid-MEM_WR aborts the store. After release the first cycle is IF.
- `mem_ready` is ignored outside IF, MEM_RD and MEM_WR.

## Structure
- Shared package `ctrl_pkg`: state encodings (4-bit, IF = 0), opcode and funct constants, ALU operation codes (the 3-bit encoding above, shared with the ALU mux).
- One sub-module, `alu_op_decode`: combinational funct → {`alu_operation`, `legal`, `is_srl`}. Used in ID for legality and in EX_R for the operation.

## Test plan
- add, `mem_ready`=1: state sequence 0→ID→EX_R→WB_R→0. `alu_operation`=010 in EX_R. `reg_write`=1 with `reg_dst`=1 exactly in cycle 4.
- lw with `mem_ready` low for 2 cycles in MEM_RD: total 7 cycles. `iord`=1 and `mem_read`=1 held through the wait. WB_LW has `mem_to_reg`=1.
- beq in EX_BEQ: with `zero`=1 → `pc_write`=1 and `pc_source`=01. With `zero`=0 → `pc_write`=0. Both return to IF after 3 cycles.
- srl (funct 000010): EX_R drives `alu_src_a`=10 and `alu_operation`=101. slt drives 111. nor drives 100.
- opcode 111111: `illegal`=1 for one cycle in ID, no write enables asserted, next state IF.
- sw stalled in MEM_WR, then `rst_n` pulled low: `mem_write` drops to 0 immediately and `state`=0. After release, IF issues `mem_read`=1.
